mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 101 ++++++++++
 tb/tb_mul_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential 8x8 unsigned shift-add multiplier that borrows an external 8-bit adder.
// Each operation runs for eight CALC cycles and then holds its product in DONE until it is taken.
module mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  add_x,
  output logic [7:0]  add_y,
  input  logic [7:0]  add_s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE and out_valid only in DONE; once out_valid is raised,
  // it and out_p stay put until out_ready is seen.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  a;
  logic [7:0]  hi;
  logic [7:0]  lo;
  logic [2:0]  cnt;
  logic        carry;
  logic [15:0] prod_nxt;

  // The adder has no carry-out, so a wrapped sum is detected by it being below add_x.
  assign carry    = (add_s < add_x);
  assign prod_nxt = {carry, add_s, lo[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_x     = 8'h00;
    add_y     = 8'h00;
    case (state)
      IDLE: in_ready = 1'b1;
      CALC: begin
        add_x = hi;
        add_y = lo[0] ? a : 8'h00;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= 8'h00;
      hi    <= 8'h00;
      lo    <= 8'h00;
      cnt   <= 3'd0;
      out_p <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a   <= in_a;
            hi  <= 8'h00;
            lo  <= in_b;
            cnt <= 3'd0;
          end
        end
        CALC: begin
          {hi, lo} <= prod_nxt;
          cnt      <= cnt + 3'd1;
          if (cnt == 3'd7) out_p <= prod_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: directed vector table, reset-in-flight sequence and a random sweep
// with backpressure, all checked against plain integer multiplication.
module tb_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic [7:0]  add_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;

  int n_pass;
  int n_total;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          hold;
    bit          noise;
  } vec_t;

  vec_t vecs[5];

  mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_s    (add_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p)
  );

  // Behavioural external adder: 8-bit sum, carry dropped.
  assign add_s = add_x + add_y;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("wait_in_ready", {15'd0, in_ready}, 16'd1);
  endtask

  // One full operation: accept, watch each CALC cycle, hold DONE, then hand off.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                        input int hold, input bit noise);
    int k;
    int part;
    logic [15:0] exp_p;
    @(negedge clk);
    wait_idle();
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    exp_q.push_back(p);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    k = 0;
    while (!out_valid && k < 20) begin
      if (k < 8) begin
        part = (int'(a) * (int'(b) & ((1 << k) - 1))) >> k;
        check("calc_add_x", {8'd0, add_x}, 16'(part));
        check("calc_add_y", {8'd0, add_y}, b[k] ? {8'd0, a} : 16'd0);
        check("calc_in_ready", {15'd0, in_ready}, 16'd0);
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    check("latency", 16'(k), 16'd8);
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check("out_p", out_p, exp_p);
    check("done_add_x", {add_x, add_y}, 16'd0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a     = 8'($urandom);
      end
      check("hold_valid", {15'd0, out_valid}, 16'd1);
      check("hold_out_p", out_p, exp_p);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", {15'd0, out_valid}, 16'd0);
    check("post_ready", {15'd0, in_ready}, 16'd1);
    check("post_out_p", out_p, exp_p);
  endtask

  initial begin
    int bad;
    logic [7:0] ra;
    logic [7:0] rb;
    n_pass    = 0;
    n_total   = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    rst_n     = 1'b0;

    vecs[0] = '{a: 8'h0D, b: 8'h0B, p: 16'h008F, hold: 0, noise: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01, hold: 0, noise: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'hA5, p: 16'h0000, hold: 1, noise: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h02, p: 16'h0100, hold: 0, noise: 1'b0};
    vecs[4] = '{a: 8'h5A, b: 8'hC3, p: 16'h448E, hold: 5, noise: 1'b1};

    #1;
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_add", {add_x, add_y}, 16'd0);
    check("rst_out_p", out_p, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].hold, vecs[i].noise);

    // Reset four cycles into CALC with a previous product still visible.
    run_op(8'h0D, 8'h0B, 16'h008F, 0, 1'b0);
    @(negedge clk);
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("calc_out_p_stable", out_p, 16'h008F);
    check("calc4_add_y", {8'd0, add_y}, 16'h00FF);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("mid_rst_add", {add_x, add_y}, 16'd0);
    check("mid_rst_out_p", out_p, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    check("no_valid_after_rst", 16'(bad), 16'd0);
    run_op(8'h12, 8'h34, 16'h03A8, 0, 1'b0);

    // Random sweep with backpressure and noise on ignored inputs.
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, 16'(int'(ra) * int'(rb)), $urandom_range(0, 2), 1'b1);
    end
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
